// File: rtl/tmds_decoder_if.sv
// Symbol-side bundle of one TMDS receive channel: raw deserialized word in,
// decoded pixel/control/enable plus alignment status out.
interface tmds_decoder_if;
  logic [9:0] i_raw;
  logic [7:0] o_data;
  logic [1:0] o_ctrl;
  logic       o_display_enable;
  logic       o_locked;
  logic [3:0] o_offset;

  modport master (
    output i_raw,
    input  o_data, o_ctrl, o_display_enable, o_locked, o_offset
  );

  modport slave (
    input  i_raw,
    output o_data, o_ctrl, o_display_enable, o_locked, o_offset
  );
endinterface

// File: rtl/tmds_decoder.sv
// TMDS channel receiver: slides a 10-bit window over the deserialized stream
// until control-token runs line up, then decodes pixel, control and enable.
module tmds_decoder #(
  parameter int LOCK_COUNT    = 16,
  parameter int SEARCH_CYCLES = 2048,
  parameter int LOSS_CYCLES   = 4096
) (
  input  logic          i_hdmi_clk,
  input  logic          i_reset_n,
  tmds_decoder_if.slave bus
);

  localparam int RUN_W   = $clog2(LOCK_COUNT + 1);
  localparam int DWELL_W = $clog2(SEARCH_CYCLES + 1);
  localparam int LOSS_W  = $clog2(LOSS_CYCLES + 1);

  localparam logic [RUN_W-1:0]   RUN_LAST   = RUN_W'(LOCK_COUNT - 1);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SEARCH_CYCLES - 1);
  localparam logic [LOSS_W-1:0]  LOSS_LAST  = LOSS_W'(LOSS_CYCLES - 1);

  typedef enum logic [1:0] {ST_SEARCH, ST_SLIP, ST_LOCKED} state_t;

  state_t             r_state, w_state_next;
  logic [8:0]         r_prev_hi;
  logic [9:0]         r_sym;
  logic [3:0]         r_offset, w_offset_next;
  logic [RUN_W-1:0]   r_runcnt, w_runcnt_next;
  logic [DWELL_W-1:0] r_dwell, w_dwell_next;
  logic [LOSS_W-1:0]  r_silence, w_silence_next;
  logic [7:0]         r_data, w_data_next;
  logic [1:0]         r_ctrl, w_ctrl_next;
  logic               r_de, w_de_next;
  logic               r_locked, w_locked_next;

  // Bit 0 of the previous word is never reachable by any offset, so only 9 bits are kept.
  logic [18:0] w_window;
  logic [9:0]  w_cand [10];
  logic [9:0]  w_aligned;
  assign w_window = {bus.i_raw, r_prev_hi};

  genvar gi;
  generate
    for (gi = 0; gi < 10; gi++) begin : gen_cand
      assign w_cand[gi] = w_window[(9 - gi) +: 10];
    end
  endgenerate
  assign w_aligned = w_cand[r_offset];

  logic       w_is_tok;
  logic [1:0] w_tok_val;
  always_comb begin
    w_is_tok  = 1'b1;
    w_tok_val = 2'b00;
    case (r_sym)
      10'b1101010100: w_tok_val = 2'b00;
      10'b0010101011: w_tok_val = 2'b01;
      10'b0101010100: w_tok_val = 2'b10;
      10'b1010101011: w_tok_val = 2'b11;
      default:        w_is_tok  = 1'b0;
    endcase
  end

  logic [7:0] w_t, w_dec;
  assign w_t      = r_sym[9] ? ~r_sym[7:0] : r_sym[7:0];
  assign w_dec[0] = w_t[0];
  generate
    for (gi = 1; gi < 8; gi++) begin : gen_dec
      assign w_dec[gi] = r_sym[8] ? (w_t[gi] ^ w_t[gi-1]) : ~(w_t[gi] ^ w_t[gi-1]);
    end
  endgenerate

  always_comb begin
    w_state_next   = r_state;
    w_offset_next  = r_offset;
    w_runcnt_next  = r_runcnt;
    w_dwell_next   = r_dwell;
    w_silence_next = r_silence;
    w_data_next    = 8'd0;
    w_ctrl_next    = 2'b00;
    w_de_next      = 1'b0;
    w_locked_next  = r_locked;
    case (r_state)
      ST_SEARCH: begin
        // Lock is tested first so a run completing on the last dwell cycle still wins.
        if (w_is_tok && r_runcnt == RUN_LAST) begin
          w_state_next   = ST_LOCKED;
          w_locked_next  = 1'b1;
          w_runcnt_next  = '0;
          w_dwell_next   = '0;
          w_silence_next = '0;
        end else if (r_dwell == DWELL_LAST) begin
          w_state_next  = ST_SLIP;
          w_offset_next = (r_offset == 4'd9) ? 4'd0 : r_offset + 4'd1;
          w_runcnt_next = '0;
          w_dwell_next  = '0;
        end else begin
          w_runcnt_next = w_is_tok ? r_runcnt + 1'b1 : '0;
          w_dwell_next  = r_dwell + 1'b1;
        end
      end
      ST_SLIP: w_state_next = ST_SEARCH;
      ST_LOCKED: begin
        if (w_is_tok) begin
          w_ctrl_next    = w_tok_val;
          w_silence_next = '0;
        end else if (r_silence == LOSS_LAST) begin
          w_state_next   = ST_SEARCH;
          w_locked_next  = 1'b0;
          w_runcnt_next  = '0;
          w_dwell_next   = '0;
          w_silence_next = '0;
        end else begin
          w_de_next      = 1'b1;
          w_data_next    = w_dec;
          w_ctrl_next    = r_ctrl;
          w_silence_next = r_silence + 1'b1;
        end
      end
      default: w_state_next = ST_SEARCH;
    endcase
  end

  always_ff @(posedge i_hdmi_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state   <= ST_SEARCH;
      r_prev_hi <= '0;
      r_sym     <= '0;
      r_offset  <= '0;
      r_runcnt  <= '0;
      r_dwell   <= '0;
      r_silence <= '0;
      r_data    <= '0;
      r_ctrl    <= '0;
      r_de      <= 1'b0;
      r_locked  <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_prev_hi <= bus.i_raw[9:1];
      r_sym     <= w_aligned;
      r_offset  <= w_offset_next;
      r_runcnt  <= w_runcnt_next;
      r_dwell   <= w_dwell_next;
      r_silence <= w_silence_next;
      r_data    <= w_data_next;
      r_ctrl    <= w_ctrl_next;
      r_de      <= w_de_next;
      r_locked  <= w_locked_next;
    end
  end

  assign bus.o_data           = r_data;
  assign bus.o_ctrl           = r_ctrl;
  assign bus.o_display_enable = r_de;
  assign bus.o_locked         = r_locked;
  assign bus.o_offset         = r_offset;

endmodule

// File: tb/tb_tmds_decoder.sv
// Directed bench for tmds_decoder: encoder-generated symbols are serialized with a
// chosen bit delay, expectations queue up as each word is driven.
module tb_tmds_decoder;
  localparam int LOCK_N   = 16;
  localparam int SEARCH_N = 32;
  localparam int LOSS_N   = 64;
  localparam logic [9:0] TOK0 = 10'b1101010100;
  localparam logic [9:0] TOK1 = 10'b0010101011;
  localparam logic [9:0] TOK2 = 10'b0101010100;
  localparam logic [9:0] TOK3 = 10'b1010101011;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  tmds_decoder_if bus();

  tmds_decoder #(
    .LOCK_COUNT(LOCK_N), .SEARCH_CYCLES(SEARCH_N), .LOSS_CYCLES(LOSS_N)
  ) dut (
    .i_hdmi_clk(clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  typedef struct packed {
    logic       locked;
    logic [3:0] offset;
    logic       de;
    logic [1:0] ctrl;
    logic [7:0] data;
  } obs_t;

  obs_t  sb_q[$];
  string tag_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    delay_bits = 0;
  int    disp = 0;
  logic [9:0] prev_sym = '0;
  logic [9:0] toks [4];
  logic [7:0] bytes_lst [9];

  function automatic obs_t mk(logic l, logic [3:0] o, logic de, logic [1:0] c, logic [7:0] d);
    return {l, o, de, c, d};
  endfunction

  function automatic obs_t observe();
    return {bus.o_locked, bus.o_offset, bus.o_display_enable, bus.o_ctrl, bus.o_data};
  endfunction

  task automatic check(input string tag, input obs_t got, input obs_t exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got lock/off/de/ctrl/data=%0b/%0d/%0b/%b/%h expected %0b/%0d/%0b/%b/%h",
             tag, got.locked, got.offset, got.de, got.ctrl, got.data,
             exp.locked, exp.offset, exp.de, exp.ctrl, exp.data);
    end
  endtask

  // DVI transmit encoder with running disparity.
  task automatic encode(input logic [7:0] d, output logic [9:0] s);
    logic [8:0] q;
    int n1d, n1q;
    n1d  = $countones(d);
    q[0] = d[0];
    if (n1d > 4 || (n1d == 4 && !d[0])) begin
      for (int i = 1; i < 8; i++) q[i] = ~(q[i-1] ^ d[i]);
      q[8] = 1'b0;
    end else begin
      for (int i = 1; i < 8; i++) q[i] = q[i-1] ^ d[i];
      q[8] = 1'b1;
    end
    n1q = $countones(q[7:0]);
    if (disp == 0 || n1q == 4) begin
      s = {~q[8], q[8], q[8] ? q[7:0] : ~q[7:0]};
      disp = q[8] ? disp + (2 * n1q - 8) : disp + (8 - 2 * n1q);
    end else if ((disp > 0 && n1q > 4) || (disp < 0 && n1q < 4)) begin
      s = {1'b1, q[8], ~q[7:0]};
      disp = disp + (q[8] ? 2 : 0) + (8 - 2 * n1q);
    end else begin
      s = {1'b0, q[8], q[7:0]};
      disp = disp - (q[8] ? 0 : 2) + (2 * n1q - 8);
    end
  endtask

  // Drives one symbol, delayed by delay_bits serial bits, then checks the symbol driven one cycle earlier.
  task automatic drive(input logic [9:0] sym, input string tag, input obs_t e);
    logic [19:0] pair;
    pair = {sym, prev_sym} >> (10 - delay_bits);
    bus.i_raw = pair[9:0];
    prev_sym  = sym;
    sb_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    if (sb_q.size() >= 2) check(tag_q.pop_front(), observe(), sb_q.pop_front());
  endtask

  task automatic reset_dut();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_reset", observe(), '0);
    @(negedge clk);
    rst_n = 1'b1;
    sb_q.delete();
    tag_q.delete();
  endtask

  // Expected outputs after the edge that consumes stream word t following a reset.
  function automatic obs_t search_exp(int t, int lock_off, logic [1:0] tv);
    int e, first_tok, lock_e;
    logic [3:0] off;
    e   = t + 1;
    off = 4'd0;
    for (int j = 0; j < lock_off; j++)
      if (e >= SEARCH_N - 1 + (SEARCH_N + 1) * j) off = 4'(j + 1);
    first_tok = (lock_off == 0) ? 1 : SEARCH_N - 1 + (SEARCH_N + 1) * (lock_off - 1) + 2;
    lock_e    = first_tok + LOCK_N - 1;
    return mk(e >= lock_e, off, 1'b0, (e >= lock_e + 1) ? tv : 2'b00, 8'h00);
  endfunction

  task automatic run_search(input int d, input logic [9:0] tok, input logic [1:0] tv,
                            input int lock_off, input int n);
    delay_bits = d;
    reset_dut();
    for (int t = 0; t < n; t++) drive(tok, $sformatf("search_d%0d_t%0d", d, t), search_exp(t, lock_off, tv));
  endtask

  initial begin
    logic [9:0] s;
    logic [7:0] b;
    toks      = '{TOK0, TOK1, TOK2, TOK3};
    bytes_lst = '{8'h00, 8'hFF, 8'h55, 8'h10, 8'hA7, 8'h03, 8'hC4, 8'h3C, 8'h81};
    bus.i_raw = '0;

    run_search(0, TOK0, 2'b00, 0, 20);

    for (int i = 0; i < 4; i++) drive(toks[i], $sformatf("ctrl%0d", i), mk(1'b1, 4'd0, 1'b0, 2'(i), 8'h00));

    disp = 0;
    for (int i = 0; i < 9; i++) begin
      encode(bytes_lst[i], s);
      drive(s, $sformatf("data_%h", bytes_lst[i]), mk(1'b1, 4'd0, 1'b1, 2'b11, bytes_lst[i]));
    end

    drive(TOK2, "ctrl_before_loss", mk(1'b1, 4'd0, 1'b0, 2'b10, 8'h00));
    for (int i = 0; i < LOSS_N; i++) begin
      b = 8'((i * 37 + 5) & 8'hFF);
      encode(b, s);
      if (i < LOSS_N - 1) drive(s, $sformatf("silence%0d", i), mk(1'b1, 4'd0, 1'b1, 2'b10, b));
      else                drive(s, "loss_drop", mk(1'b0, 4'd0, 1'b0, 2'b00, 8'h00));
    end

    for (int i = 0; i < LOCK_N + 2; i++)
      drive(TOK1, $sformatf("relock%0d", i),
            mk(i >= LOCK_N - 1, 4'd0, 1'b0, (i >= LOCK_N) ? 2'b01 : 2'b00, 8'h00));

    run_search(7, TOK2, 2'b10, 3, 125);
    run_search(5, TOK3, 2'b11, 5, 190);
    run_search(5, TOK3, 2'b11, 5, 40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
